// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU: single-cycle integer ops complete in one cycle,
// MUL/DIVU/REMU iterate once per bit in BUSY before presenting the result.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             negative_flag,
  output logic             zero_flag,
  output logic             overflow_flag,
  output logic [1:0]       state_dbg
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] SH_LIM = (SHW+1)'(WIDTH);
  localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and ready depends only on registered state.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_q, c_d, n_q, n_d, z_q, z_d, v_q, v_d;

  logic               cin;
  logic [WIDTH:0]     add_s, sub_d, shl_t, shr_t, sar_t;
  logic [WIDTH-1:0]   rol_r;
  logic [SHW-1:0]     sh;
  logic               sh_zero;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c, sc_v;

  // Single-cycle datapath, evaluated on the live inputs at accept time.
  always_comb begin
    cin     = (op == 4'd1 || op == 4'd3) ? c_q : 1'b0;
    add_s   = {1'b0, num1} + {1'b0, num2} + {{WIDTH{1'b0}}, cin};
    sub_d   = {1'b0, num1} - {1'b0, num2} - {{WIDTH{1'b0}}, cin};
    sh      = num2[SHW-1:0];
    sh_zero = (sh == '0);
    shl_t   = {1'b0, num1} << sh;
    shr_t   = {num1, 1'b0} >> sh;
    sar_t   = $signed({num1, 1'b0}) >>> sh;
    rol_r   = (num1 << sh) | (num1 >> (SH_LIM - {1'b0, sh}));
    if ({1'b0, sh} >= SH_LIM) rol_r = '0;
    sc_res  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        sc_res = add_s[WIDTH-1:0];
        sc_c   = add_s[WIDTH];
        sc_v   = (num1[WIDTH-1] == num2[WIDTH-1]) && (add_s[WIDTH-1] != num1[WIDTH-1]);
      end
      4'd2, 4'd3: begin
        sc_res = sub_d[WIDTH-1:0];
        sc_c   = sub_d[WIDTH];
        sc_v   = (num1[WIDTH-1] != num2[WIDTH-1]) && (sub_d[WIDTH-1] != num1[WIDTH-1]);
      end
      4'd4:  sc_res = num1 & num2;
      4'd5:  sc_res = num1 | num2;
      4'd6:  sc_res = num1 ^ num2;
      4'd7:  sc_res = ~num1;
      4'd8: begin
        sc_res = shl_t[WIDTH-1:0];
        sc_c   = ~sh_zero & shl_t[WIDTH];
      end
      4'd9: begin
        sc_res = shr_t[WIDTH:1];
        sc_c   = ~sh_zero & shr_t[0];
      end
      4'd10: begin
        sc_res = sar_t[WIDTH:1];
        sc_c   = ~sh_zero & sar_t[0];
      end
      4'd11: begin
        sc_res = rol_r;
        sc_c   = ~sh_zero & rol_r[0];
      end
      default: sc_res = num2;
    endcase
  end

  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] step;
  logic [WIDTH-1:0]   it_res;
  logic               it_c, it_v;

  // One iteration: MUL shifts {acc, multiplier} right; DIV shifts {rem, quot} left.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    div_sh   = prod_q[2*WIDTH-1:WIDTH-1];
    div_ge   = div_sh >= {1'b0, b_q};
    div_diff = div_sh[WIDTH-1:0] - b_q;
    if (op_q == 4'd12) step = {mul_sum, prod_q[WIDTH-1:1]};
    else step = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), prod_q[WIDTH-2:0], div_ge};
    it_res = (op_q == 4'd14) ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
    it_c   = (op_q == 4'd12) && (step[2*WIDTH-1:WIDTH] != '0);
    it_v   = (op_q == 4'd12) ? it_c : (b_q == '0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    result_d = result_q;
    c_d      = c_q;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d   = op;
          a_d    = num1;
          b_d    = num2;
          prod_d = {{WIDTH{1'b0}}, (op == 4'd12) ? num2 : num1};
          if (op >= 4'd12 && op <= 4'd14) begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d  = S_DONE;
            result_d = sc_res;
            c_d      = sc_c;
            v_d      = sc_v;
            n_d      = sc_res[WIDTH-1];
            z_d      = (sc_res == '0);
          end
        end
      end
      S_BUSY: begin
        prod_d = step;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = it_res;
          c_d      = it_c;
          v_d      = it_v;
          n_d      = it_res[WIDTH-1];
          z_d      = (it_res == '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      c_q      <= c_d;
      n_q      <= n_d;
      z_q      <= z_d;
      v_q      <= v_d;
    end
  end

  // The stored carry for ADC/SBB is the carry flag register itself.
  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_DONE);
  assign result        = result_q;
  assign carry_flag    = c_q;
  assign negative_flag = n_q;
  assign zero_flag     = z_q;
  assign overflow_flag = v_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed table-driven bench for alu_mc at WIDTH = 8, with hand-written
// sequences for output stall and reset during a multiply.
module tb_alu_mc;
  localparam int W = 8;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] num1, num2, result;
  logic         carry_flag, negative_flag, zero_flag, overflow_flag;
  logic [1:0]   state_dbg;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .num1(num1), .num2(num2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_flag(carry_flag), .negative_flag(negative_flag),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // flags packed as {C, N, Z, V}
  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   f;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Driver: accept, wait for result with bounded latency, check; caller handshakes.
  task automatic issue(input vec_t v);
    int cyc;
    int lat_exp;
    logic busy_ok;
    logic [W-1:0] exp_r;
    lat_exp = (v.op >= 4'd12 && v.op <= 4'd14) ? W + 1 : 1;
    exp_q.push_back(v.res);
    chk("accept_ready", in_ready, 1'b1);
    op = v.op; num1 = v.a; num2 = v.b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op   = 4'($urandom_range(0, 15));
    num1 = 8'($urandom_range(0, 255));
    num2 = 8'($urandom_range(0, 255));
    cyc = 1;
    busy_ok = 1'b1;
    while (!out_valid && cyc < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, lat_exp);
    if (lat_exp > 1) chk("busy_in_ready_low", busy_ok, 1'b1);
    exp_r = exp_q.pop_front();
    chk("result", result, exp_r);
    chk("flags_cnzv", {carry_flag, negative_flag, zero_flag, overflow_flag}, v.f);
  endtask

  task automatic run_op(input vec_t v);
    issue(v);
    @(posedge clk); #1;
    chk("post_handshake", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    logic no_pulse;
    vec_t sv;
    vecs[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 4'b1010};
    vecs[1]  = '{4'd1,  8'h00, 8'h00, 8'h01, 4'b0000};
    vecs[2]  = '{4'd2,  8'h80, 8'h01, 8'h7F, 4'b0001};
    vecs[3]  = '{4'd2,  8'h01, 8'h02, 8'hFF, 4'b1100};
    vecs[4]  = '{4'd3,  8'h05, 8'h01, 8'h03, 4'b0000};
    vecs[5]  = '{4'd8,  8'h81, 8'h01, 8'h02, 4'b1000};
    vecs[6]  = '{4'd10, 8'h80, 8'h03, 8'hF0, 4'b0100};
    vecs[7]  = '{4'd11, 8'h81, 8'h01, 8'h03, 4'b1000};
    vecs[8]  = '{4'd9,  8'h5A, 8'h00, 8'h5A, 4'b0000};
    vecs[9]  = '{4'd4,  8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[10] = '{4'd5,  8'hF0, 8'h0C, 8'hFC, 4'b0100};
    vecs[11] = '{4'd6,  8'hAA, 8'hAA, 8'h00, 4'b0010};
    vecs[12] = '{4'd7,  8'h0F, 8'h77, 8'hF0, 4'b0100};
    vecs[13] = '{4'd15, 8'h11, 8'h80, 8'h80, 4'b0100};
    vecs[14] = '{4'd12, 8'h10, 8'h20, 8'h00, 4'b1011};
    vecs[15] = '{4'd12, 8'h0F, 8'h0F, 8'hE1, 4'b0100};
    vecs[16] = '{4'd13, 8'hC8, 8'h07, 8'h1C, 4'b0000};
    vecs[17] = '{4'd14, 8'hC8, 8'h07, 8'h04, 4'b0000};
    vecs[18] = '{4'd13, 8'h55, 8'h00, 8'hFF, 4'b0101};
    vecs[19] = '{4'd14, 8'h55, 8'h00, 8'h55, 4'b0001};
    vecs[20] = '{4'd1,  8'h7F, 8'h01, 8'h80, 4'b0101};
    vecs[21] = '{4'd9,  8'h88, 8'h04, 8'h08, 4'b1000};
    vecs[22] = '{4'd1,  8'hFF, 8'h00, 8'h00, 4'b1010};
    vecs[23] = '{4'd3,  8'h00, 8'h00, 8'hFF, 4'b1100};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'd0; num1 = '0; num2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_handshake", {in_ready, out_valid}, 2'b10);
    chk("reset_result", result, 8'h00);
    chk("reset_flags", {carry_flag, negative_flag, zero_flag, overflow_flag}, 4'b0000);

    for (int i = 0; i < NV; i++) run_op(vecs[i]);

    // Output stall: result held stable, new requests ignored until drained.
    out_ready = 1'b0;
    sv = '{4'd2, 8'h01, 8'h02, 8'hFF, 4'b1100};
    issue(sv);
    in_valid = 1'b1; op = 4'd0; num1 = 8'h01; num2 = 8'h01;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_valid_ready", {out_valid, in_ready}, 2'b10);
      chk("stall_result", result, 8'hFF);
      chk("stall_flags", {carry_flag, negative_flag, zero_flag, overflow_flag}, 4'b1100);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_drain", {in_ready, out_valid}, 2'b10);
    chk("stall_drain_result", result, 8'hFF);

    // Reset during the 4th BUSY cycle of a multiply aborts it.
    op = 4'd12; num1 = 8'h03; num2 = 8'h05; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mul_busy_before_reset", {in_ready, out_valid}, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_handshake", {in_ready, out_valid}, 2'b10);
    chk("abort_result", result, 8'h00);
    chk("abort_flags", {carry_flag, negative_flag, zero_flag, overflow_flag}, 4'b0000);
    no_pulse = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) no_pulse = 1'b0;
    end
    chk("abort_no_out_valid", no_pulse, 1'b1);

    // Stored carry cleared by reset: ADC adds no carry-in.
    sv = '{4'd1, 8'h01, 8'h01, 8'h02, 4'b0000};
    run_op(sv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
